// File: rtl/vh_stim_pkg.sv
// Shared constants, state encoding and LFSR helper for the vloghammer stimulus driver.
// The VH_STIM_CORNER_EN build option (see vh_stim_driver) uses the corner patterns defined here.
package vh_stim_pkg;

  localparam int Y_W    = 90;
  localparam int OPS_W  = 60;
  localparam int LFSR_W = 64;
  localparam int SIG_W  = 32;

  // Operand fields inside the low 60 LFSR bits, LSB first.
  localparam int A0_OFF = 0,  A0_W = 4;
  localparam int A1_OFF = 4,  A1_W = 5;
  localparam int A2_OFF = 9,  A2_W = 6;
  localparam int A3_OFF = 15, A3_W = 4;
  localparam int A4_OFF = 19, A4_W = 5;
  localparam int A5_OFF = 24, A5_W = 6;
  localparam int B0_OFF = 30, B0_W = 4;
  localparam int B1_OFF = 34, B1_W = 5;
  localparam int B2_OFF = 39, B2_W = 6;
  localparam int B3_OFF = 45, B3_W = 4;
  localparam int B4_OFF = 49, B4_W = 5;
  localparam int B5_OFF = 54, B5_W = 6;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [SIG_W-1:0]  MISR_POLY = 32'h04C1_1DB7;
  localparam logic [SIG_W-1:0]  MISR_INIT = 32'hFFFF_FFFF;

  // Fields repeat as a 4/5/6-bit group every 15 bits, so each corner is a 15-bit pattern x4.
  localparam int              NUM_CORNERS = 4;
  localparam logic [OPS_W-1:0] CORNER_ZERO = '0;
  localparam logic [OPS_W-1:0] CORNER_ONES = '1;
  localparam logic [OPS_W-1:0] CORNER_MSB  = {4{15'h4108}};
  localparam logic [OPS_W-1:0] CORNER_LOW  = {4{15'h3EF7}};

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic [OPS_W-1:0] corner_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    return CORNER_ZERO;
      2'd1:    return CORNER_ONES;
      2'd2:    return CORNER_MSB;
      default: return CORNER_LOW;
    endcase
  endfunction

endpackage

// File: rtl/vh_misr32.sv
// 32-bit MISR that folds a 90-bit response into a running signature.
// Shared with other regression checkers; clear and reset both restore the init value.
module vh_misr32
  import vh_stim_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [Y_W-1:0]   y,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] fold;

  assign fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};

  // NOTE: non-blocking so every register in the design samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) sig <= MISR_INIT;
    else if (en)        sig <= {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : '0) ^ fold;
  end

endmodule

// File: rtl/vh_stim_driver.sv
// LFSR operand driver and MISR response compactor for one vloghammer expression DUT.
// Define VH_STIM_CORNER_EN to replace the first four vectors of each run with corner patterns.
module vh_stim_driver
  import vh_stim_pkg::*;
#(
  parameter int unsigned        NUM_VECTORS = 256,
  parameter logic [LFSR_W-1:0]  SEED        = 64'h0000_0000_0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Y_W-1:0]   y,
  output logic [A0_W-1:0]  a0,
  output logic [A1_W-1:0]  a1,
  output logic [A2_W-1:0]  a2,
  output logic [A3_W-1:0]  a3,
  output logic [A4_W-1:0]  a4,
  output logic [A5_W-1:0]  a5,
  output logic [B0_W-1:0]  b0,
  output logic [B1_W-1:0]  b1,
  output logic [B2_W-1:0]  b2,
  output logic [B3_W-1:0]  b3,
  output logic [B4_W-1:0]  b4,
  output logic [B5_W-1:0]  b5,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      vec_count
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 64'd1 : SEED;
  localparam logic [16:0]       LAST_CNT = 17'(NUM_VECTORS);

  state_t            state, state_nx;
  logic [LFSR_W-1:0] lfsr, lfsr_adv, lfsr_step;
  logic [OPS_W-1:0]  ops, start_ops, next_ops;
  logic              launch, last_vec;

  assign launch   = start && (state == IDLE || state == DONE);
  assign last_vec = ({1'b0, vec_count} + 17'd1) == LAST_CNT;
  assign lfsr_adv = lfsr_next(lfsr);

`ifdef VH_STIM_CORNER_EN
  logic in_corner, next_corner;

  // The LFSR stays parked at the seed until the corner vectors are used up.
  assign in_corner   = vec_count < 16'(NUM_CORNERS);
  assign next_corner = ({1'b0, vec_count} + 17'd1) < 17'(NUM_CORNERS);
  assign start_ops   = corner_pattern(2'd0);
  assign lfsr_step   = in_corner ? lfsr : lfsr_adv;
  assign next_ops    = next_corner ? corner_pattern(vec_count[1:0] + 2'd1) : lfsr_step[OPS_W-1:0];
`else
  assign start_ops   = SEED_EFF[OPS_W-1:0];
  assign lfsr_step   = lfsr_adv;
  assign next_ops    = lfsr_adv[OPS_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = APPLY;
      APPLY:      state_nx = SAMPLE;
      SAMPLE:     state_nx = last_vec ? DONE : APPLY;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= SEED_EFF;
      ops       <= '0;
      vec_count <= '0;
    end else if (launch) begin
      lfsr      <= SEED_EFF;
      ops       <= start_ops;
      vec_count <= '0;
    end else if (state == SAMPLE) begin
      lfsr      <= lfsr_step;
      vec_count <= vec_count + 16'd1;
      if (!last_vec) ops <= next_ops;
    end
  end

  vh_misr32 u_misr (
    .clk   (clk),
    .reset (reset),
    .clear (launch),
    .en    (state == SAMPLE),
    .y     (y),
    .sig   (sig)
  );

  assign busy = (state == APPLY) || (state == SAMPLE);
  assign done = (state == DONE);

  assign a0 = ops[A0_OFF +: A0_W];
  assign a1 = ops[A1_OFF +: A1_W];
  assign a2 = ops[A2_OFF +: A2_W];
  assign a3 = ops[A3_OFF +: A3_W];
  assign a4 = ops[A4_OFF +: A4_W];
  assign a5 = ops[A5_OFF +: A5_W];
  assign b0 = ops[B0_OFF +: B0_W];
  assign b1 = ops[B1_OFF +: B1_W];
  assign b2 = ops[B2_OFF +: B2_W];
  assign b3 = ops[B3_OFF +: B3_W];
  assign b4 = ops[B4_OFF +: B4_W];
  assign b5 = ops[B5_OFF +: B5_W];

endmodule

// File: tb/tb_vh_stim_driver.sv
// Directed bench for vh_stim_driver: several instances with different NUM_VECTORS/SEED
// share one clock and reset; corner-mode checks run when VH_STIM_CORNER_EN is defined.
`timescale 1ns/1ps
module tb_vh_stim_driver;

  logic clk;
  logic reset;
  logic s1, s2, s8;
  int   total  = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`define OPS_PORTS(v) \
  .a0(v[3:0]), .a1(v[8:4]), .a2(v[14:9]), .a3(v[18:15]), .a4(v[23:19]), .a5(v[29:24]), \
  .b0(v[33:30]), .b1(v[38:34]), .b2(v[44:39]), .b3(v[48:45]), .b4(v[53:49]), .b5(v[59:54])

  // Reference expression DUT used to loop y back from the operands.
  function automatic logic [89:0] ref_y(input logic [59:0] o);
    return {o[29:0], o ^ {o[29:0], o[59:30]}};
  endfunction

  function automatic logic [63:0] m_next(input logic [63:0] l);
    logic [63:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 64'hD800_0000_0000_0000;
    return r;
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [89:0] yv);
    logic [31:0] r;
    r = {s[30:0], 1'b0};
    if (s[31]) r = r ^ 32'h04C1_1DB7;
    return r ^ yv[31:0] ^ yv[63:32] ^ {6'b0, yv[89:64]};
  endfunction

  function automatic logic [59:0] model_ops(input logic [63:0] seed, input int idx, input bit corner);
    logic [63:0] l;
    int j;
    l = (seed == 64'd0) ? 64'd1 : seed;
    if (corner && idx < 4) begin
      case (idx)
        0: return 60'h0;
        1: return 60'hFFF_FFFF_FFFF_FFFF;
        2: return {4{15'h4108}};
        default: return {4{15'h3EF7}};
      endcase
    end
    j = corner ? idx - 4 : idx;
    for (int k = 0; k < j; k++) l = m_next(l);
    return l[59:0];
  endfunction

  function automatic logic [31:0] model_sig(input logic [63:0] seed, input int n, input bit corner);
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) s = m_misr(s, ref_y(model_ops(seed, i, corner)));
    return s;
  endfunction

  wire [59:0] ops1, ops2, ops8, ops8z;
  logic busy1, done1, busy2, done2, busy8, done8, busy8z, done8z;
  logic [31:0] sig1, sig2, sig8, sig8z;
  logic [15:0] vc1, vc2, vc8, vc8z;

  vh_stim_driver #(.NUM_VECTORS(1), .SEED(64'd1)) u1 (
    .clk(clk), .reset(reset), .start(s1), .y(90'd0), `OPS_PORTS(ops1),
    .busy(busy1), .done(done1), .sig(sig1), .vec_count(vc1));

  vh_stim_driver #(.NUM_VECTORS(2), .SEED(64'd1)) u2 (
    .clk(clk), .reset(reset), .start(s2), .y(90'd0), `OPS_PORTS(ops2),
    .busy(busy2), .done(done2), .sig(sig2), .vec_count(vc2));

  vh_stim_driver #(.NUM_VECTORS(8), .SEED(64'd1)) u8 (
    .clk(clk), .reset(reset), .start(s8), .y(ref_y(ops8)), `OPS_PORTS(ops8),
    .busy(busy8), .done(done8), .sig(sig8), .vec_count(vc8));

  vh_stim_driver #(.NUM_VECTORS(8), .SEED(64'd0)) u8z (
    .clk(clk), .reset(reset), .start(s8), .y(ref_y(ops8z)), `OPS_PORTS(ops8z),
    .busy(busy8z), .done(done8z), .sig(sig8z), .vec_count(vc8z));

`ifdef VH_STIM_CORNER_EN
  logic s4;
  wire [59:0] ops4;
  logic busy4, done4;
  logic [31:0] sig4;
  logic [15:0] vc4;

  vh_stim_driver #(.NUM_VECTORS(4), .SEED(64'd1)) u4c (
    .clk(clk), .reset(reset), .start(s4), .y(ref_y(ops4)), `OPS_PORTS(ops4),
    .busy(busy4), .done(done4), .sig(sig4), .vec_count(vc4));
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy1); else passed++;
    total++; if (done1 !== 1'b0) $display("FAIL reset_done: got %b want 0", done1); else passed++;
    total++; if (sig1 !== 32'hFFFF_FFFF) $display("FAIL reset_sig: got %h want ffffffff", sig1); else passed++;
    total++; if (vc1 !== 16'd0) $display("FAIL reset_vec_count: got %0d want 0", vc1); else passed++;
    total++; if (ops1 !== 60'd0) $display("FAIL reset_operands: got %h want 0", ops1); else passed++;
  endtask

  task automatic test_single();
    s1 = 1'b1;
    step();                       // edge 0
    s1 = 1'b0;
    step();                       // edge 1
    total++; if (ops1 !== 60'h1) $display("FAIL n1_operands: got %h want 1", ops1); else passed++;
    total++; if (busy1 !== 1'b1) $display("FAIL n1_busy: got %b want 1", busy1); else passed++;
    total++; if (done1 !== 1'b0) $display("FAIL n1_done_early: got %b want 0", done1); else passed++;
    step();                       // edge 2
    total++; if (done1 !== 1'b1) $display("FAIL n1_done: got %b want 1", done1); else passed++;
    total++; if (vc1 !== 16'd1) $display("FAIL n1_vec_count: got %0d want 1", vc1); else passed++;
    total++; if (sig1 !== 32'hFB3E_E249) $display("FAIL n1_sig: got %h want fb3ee249", sig1); else passed++;
  endtask

  task automatic test_two();
    s2 = 1'b1;
    step();                       // edge 0
    s2 = 1'b0;
    step(); step(); step();       // edges 1..3
    total++; if (ops2 !== 60'h800_0000_0000_0000) $display("FAIL n2_vec1_operands: got %h want 800000000000000", ops2); else passed++;
    total++; if ($signed(ops2[59:54]) !== -6'sd32) $display("FAIL n2_b5_signed: got %0d want -32", $signed(ops2[59:54])); else passed++;
    total++; if (done2 !== 1'b0) $display("FAIL n2_done_early: got %b want 0", done2); else passed++;
    step();                       // edge 4
    total++; if (done2 !== 1'b1) $display("FAIL n2_done: got %b want 1", done2); else passed++;
    total++; if (vc2 !== 16'd2) $display("FAIL n2_vec_count: got %0d want 2", vc2); else passed++;
    total++; if (sig2 !== 32'hF2BC_D925) $display("FAIL n2_sig: got %h want f2bcd925", sig2); else passed++;
  endtask

  task automatic test_seed0();
    s8 = 1'b1;
    step();                       // edge 0
    s8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();                     // edge 1+2i
      total++;
      if (ops8 !== model_ops(64'd1, i, 1'b0))
        $display("FAIL n8_vec%0d_operands: got %h want %h", i, ops8, model_ops(64'd1, i, 1'b0));
      else passed++;
      step();                     // edge 2+2i
    end
    total++; if (done8 !== 1'b1 || done8z !== 1'b1) $display("FAIL n8_done: got %b/%b want 1/1", done8, done8z); else passed++;
    total++; if (sig8 !== model_sig(64'd1, 8, 1'b0)) $display("FAIL n8_sig: got %h want %h", sig8, model_sig(64'd1, 8, 1'b0)); else passed++;
    total++; if (sig8z !== model_sig(64'd1, 8, 1'b0)) $display("FAIL seed0_sig: got %h want %h", sig8z, model_sig(64'd1, 8, 1'b0)); else passed++;
  endtask

  task automatic test_reset_midrun();
    int e;
    s8 = 1'b1;
    step();                       // edge 0
    s8 = 1'b0;
    step(); step(); step(); step();
    reset = 1'b1;
    step();                       // edge 5
    reset = 1'b0;
    step();                       // edge 6
    total++; if (busy8 !== 1'b0 || done8 !== 1'b0) $display("FAIL midreset_state: got busy %b done %b want 0 0", busy8, done8); else passed++;
    total++; if (ops8 !== 60'd0) $display("FAIL midreset_operands: got %h want 0", ops8); else passed++;
    total++; if (sig8 !== 32'hFFFF_FFFF) $display("FAIL midreset_sig: got %h want ffffffff", sig8); else passed++;
    total++; if (vc8 !== 16'd0) $display("FAIL midreset_vec_count: got %0d want 0", vc8); else passed++;
    s8 = 1'b1;
    step();
    s8 = 1'b0;
    e = 0;
    while (!done8 && e < 40) begin step(); e++; end
    total++; if (e !== 16) $display("FAIL rerun_done_edge: got %0d want 16", e); else passed++;
    total++; if (sig8 !== model_sig(64'd1, 8, 1'b0)) $display("FAIL rerun_sig: got %h want %h", sig8, model_sig(64'd1, 8, 1'b0)); else passed++;
  endtask

  task automatic test_start_held();
    int e;
    s8 = 1'b1;
    step();                       // edge 0
    e = 0;
    while (!done8 && e < 40) begin step(); e++; end
    total++; if (e !== 16) $display("FAIL held_done_edge: got %0d want 16", e); else passed++;
    total++; if (vc8 !== 16'd8) $display("FAIL held_vec_count: got %0d want 8", vc8); else passed++;
    step();
    total++; if (busy8 !== 1'b1 || done8 !== 1'b0) $display("FAIL held_relaunch: got busy %b done %b want 1 0", busy8, done8); else passed++;
    total++; if (vc8 !== 16'd0) $display("FAIL held_relaunch_count: got %0d want 0", vc8); else passed++;
    e = 0;
    while (!done8 && e < 40) begin step(); e++; end
    s8 = 1'b0;
    total++; if (e !== 16) $display("FAIL held_second_done_edge: got %0d want 16", e); else passed++;
    total++; if (sig8 !== model_sig(64'd1, 8, 1'b0)) $display("FAIL held_sig: got %h want %h", sig8, model_sig(64'd1, 8, 1'b0)); else passed++;
  endtask

`ifdef VH_STIM_CORNER_EN
  task automatic test_corner();
    s4 = 1'b1;
    step();                       // edge 0
    s4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();                     // edge 1+2i
      total++;
      if (ops4 !== model_ops(64'd1, i, 1'b1))
        $display("FAIL corner%0d_operands: got %h want %h", i, ops4, model_ops(64'd1, i, 1'b1));
      else passed++;
      step();
    end
    total++; if (done4 !== 1'b1) $display("FAIL corner_done: got %b want 1", done4); else passed++;
    total++; if (u4c.lfsr !== 64'd1) $display("FAIL corner_lfsr: got %h want 1", u4c.lfsr); else passed++;
    total++; if (sig4 !== model_sig(64'd1, 4, 1'b1)) $display("FAIL corner_sig: got %h want %h", sig4, model_sig(64'd1, 4, 1'b1)); else passed++;
  endtask
`endif

  initial begin
    reset = 1'b1;
    s1 = 1'b0; s2 = 1'b0; s8 = 1'b0;
`ifdef VH_STIM_CORNER_EN
    s4 = 1'b0;
`endif
    test_reset();
`ifdef VH_STIM_CORNER_EN
    test_corner();
`else
    test_single();
    test_two();
    test_seed0();
    test_reset_midrun();
    test_start_held();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
